// File: rtl/facelet_pkg.sv
// Shared definitions for the facelet capture sequencer.
// Holds the cube geometry constants, the sequencer state type and
// a helper that locates one facelet inside the packed colour vectors.
package facelet_pkg;

   localparam int unsigned NUM_FACES         = 6;
   localparam int unsigned FACELETS_PER_FACE = 9;
   localparam int unsigned NUM_FACELETS      = 54;
   localparam int unsigned CH_W              = 8;
   localparam int unsigned GRID_N            = 3;
   localparam int unsigned STORE_W           = NUM_FACELETS * CH_W;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SOF,
      ACCUM,
      COMMIT,
      DONE
   } sampler_state_t;

   // Facelet 0 sits in the top byte, so facelet i starts at bit 431 - 8i.
   function automatic int unsigned facelet_msb(input int unsigned i);
      return STORE_W - 1 - CH_W * i;
   endfunction

endpackage

// File: rtl/facelet_window_decode.sv
// Maps a pixel coordinate onto one of the 3x3 sampling windows.
// Ports:
//   PixX, PixY : pixel column / row
//   in_win     : pixel lies inside some window
//   win_idx    : window index k = 3*row + col (valid when in_win)
module facelet_window_decode
   import facelet_pkg::*;
#(
   parameter int unsigned GRID_X0    = 200,
   parameter int unsigned GRID_Y0    = 120,
   parameter int unsigned GRID_PITCH = 80,
   parameter int unsigned WIN_LOG2   = 3
) (
   input  logic [9:0] PixX,
   input  logic [9:0] PixY,
   output logic       in_win,
   output logic [3:0] win_idx
);

   localparam int unsigned WIN  = 1 << WIN_LOG2;
   localparam int unsigned HALF = WIN / 2;

   logic [31:0]       px;
   logic [31:0]       py;
   logic [GRID_N-1:0] col_hit;
   logic [GRID_N-1:0] row_hit;

   assign px = 32'(PixX);
   assign py = 32'(PixY);

   // Window spans [centre - WIN/2, centre + WIN/2 - 1] on each axis.
   always_comb begin
      col_hit = '0;
      row_hit = '0;
      in_win  = 1'b0;
      win_idx = '0;
      for (int unsigned i = 0; i < GRID_N; i++) begin
         col_hit[i] = (px >= GRID_X0 + i * GRID_PITCH - HALF) &&
                      (px <= GRID_X0 + i * GRID_PITCH + HALF - 1);
         row_hit[i] = (py >= GRID_Y0 + i * GRID_PITCH - HALF) &&
                      (py <= GRID_Y0 + i * GRID_PITCH + HALF - 1);
      end
      for (int unsigned r = 0; r < GRID_N; r++) begin
         for (int unsigned c = 0; c < GRID_N; c++) begin
            if (row_hit[r] && col_hit[c]) begin
               in_win  = 1'b1;
               win_idx = 4'(r * GRID_N + c);
            end
         end
      end
   end

endmodule

// File: rtl/facelet_sampler.sv
// Capture sequencer filling the 54-facelet RGB store for the VGA colour mapper.
// On a capture request it waits for a frame start, sums RGB over 9 grid
// windows for one whole frame, then writes the 9 averages into the chosen
// face's slots, one facelet per cycle.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   frame_start         : first pixel of a camera frame
//   pix_valid, PixX/Y   : pixel strobe and coordinate
//   PixR/G/B            : pixel colour
//   capture_req,face_sel: capture request and target face (0-5)
//   Color_R/G/B         : packed colour store, facelet i at [431-8i -: 8]
//   busy, done, err     : status; done/err are one-cycle pulses
module facelet_sampler
   import facelet_pkg::*;
#(
   parameter int unsigned GRID_X0    = 200,
   parameter int unsigned GRID_Y0    = 120,
   parameter int unsigned GRID_PITCH = 80,
   parameter int unsigned WIN_LOG2   = 3
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_start,
   input  logic               pix_valid,
   input  logic [9:0]         PixX,
   input  logic [9:0]         PixY,
   input  logic [7:0]         PixR,
   input  logic [7:0]         PixG,
   input  logic [7:0]         PixB,
   input  logic               capture_req,
   input  logic [2:0]         face_sel,
   output logic [STORE_W-1:0] Color_R,
   output logic [STORE_W-1:0] Color_G,
   output logic [STORE_W-1:0] Color_B,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int unsigned ACC_W = CH_W + 2 * WIN_LOG2;

   sampler_state_t     state_q, state_d;
   logic [2:0]         face_q, face_d;
   logic [3:0]         idx_q, idx_d;
   logic [ACC_W-1:0]   acc_r_q [FACELETS_PER_FACE];
   logic [ACC_W-1:0]   acc_g_q [FACELETS_PER_FACE];
   logic [ACC_W-1:0]   acc_b_q [FACELETS_PER_FACE];
   logic [ACC_W-1:0]   acc_r_d [FACELETS_PER_FACE];
   logic [ACC_W-1:0]   acc_g_d [FACELETS_PER_FACE];
   logic [ACC_W-1:0]   acc_b_d [FACELETS_PER_FACE];
   logic [STORE_W-1:0] color_r_q, color_r_d;
   logic [STORE_W-1:0] color_g_q, color_g_d;
   logic [STORE_W-1:0] color_b_q, color_b_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               in_win;
   logic [3:0]         win_idx;
   logic               acc_en;
   int unsigned        fl_msb;

   facelet_window_decode #(
      .GRID_X0    (GRID_X0),
      .GRID_Y0    (GRID_Y0),
      .GRID_PITCH (GRID_PITCH),
      .WIN_LOG2   (WIN_LOG2)
   ) u_decode (
      .PixX    (PixX),
      .PixY    (PixY),
      .in_win  (in_win),
      .win_idx (win_idx)
   );

   assign acc_en = pix_valid && in_win;

   always_comb begin
      state_d   = state_q;
      face_d    = face_q;
      idx_d     = idx_q;
      acc_r_d   = acc_r_q;
      acc_g_d   = acc_g_q;
      acc_b_d   = acc_b_q;
      color_r_d = color_r_q;
      color_g_d = color_g_q;
      color_b_d = color_b_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      fl_msb    = facelet_msb(32'(face_q) * FACELETS_PER_FACE + 32'(idx_q));

      unique case (state_q)
         IDLE: begin
            if (capture_req) begin
               if (32'(face_sel) < NUM_FACES) begin
                  face_d  = face_sel;
                  acc_r_d = '{default: '0};
                  acc_g_d = '{default: '0};
                  acc_b_d = '{default: '0};
                  state_d = WAIT_SOF;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         WAIT_SOF: begin
            // The frame_start cycle carries the frame's first pixel.
            if (frame_start) begin
               state_d = ACCUM;
               if (acc_en) begin
                  acc_r_d[win_idx] = acc_r_q[win_idx] + ACC_W'(PixR);
                  acc_g_d[win_idx] = acc_g_q[win_idx] + ACC_W'(PixG);
                  acc_b_d[win_idx] = acc_b_q[win_idx] + ACC_W'(PixB);
               end
            end
         end
         ACCUM: begin
            // The next frame's first pixel is not part of this frame.
            if (frame_start) begin
               state_d = COMMIT;
               idx_d   = '0;
            end else if (acc_en) begin
               acc_r_d[win_idx] = acc_r_q[win_idx] + ACC_W'(PixR);
               acc_g_d[win_idx] = acc_g_q[win_idx] + ACC_W'(PixG);
               acc_b_d[win_idx] = acc_b_q[win_idx] + ACC_W'(PixB);
            end
         end
         COMMIT: begin
            color_r_d[fl_msb -: CH_W] = CH_W'(acc_r_q[idx_q] >> (2 * WIN_LOG2));
            color_g_d[fl_msb -: CH_W] = CH_W'(acc_g_q[idx_q] >> (2 * WIN_LOG2));
            color_b_d[fl_msb -: CH_W] = CH_W'(acc_b_q[idx_q] >> (2 * WIN_LOG2));
            idx_d = idx_q + 4'd1;
            if (32'(idx_q) == FACELETS_PER_FACE - 1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         face_q    <= '0;
         idx_q     <= '0;
         acc_r_q   <= '{default: '0};
         acc_g_q   <= '{default: '0};
         acc_b_q   <= '{default: '0};
         color_r_q <= '0;
         color_g_q <= '0;
         color_b_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         face_q    <= face_d;
         idx_q     <= idx_d;
         acc_r_q   <= acc_r_d;
         acc_g_q   <= acc_g_d;
         acc_b_q   <= acc_b_d;
         color_r_q <= color_r_d;
         color_g_q <= color_g_d;
         color_b_q <= color_b_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign Color_R = color_r_q;
   assign Color_G = color_g_q;
   assign Color_B = color_b_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_facelet_sampler.sv
// Scoreboard bench for facelet_sampler: stimulus pushes the expected store
// (or an err event) into a queue; a monitor pops and compares on done/err.
module tb_facelet_sampler;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         frame_start;
   logic         pix_valid;
   logic [9:0]   PixX;
   logic [9:0]   PixY;
   logic [7:0]   PixR;
   logic [7:0]   PixG;
   logic [7:0]   PixB;
   logic         capture_req;
   logic [2:0]   face_sel;
   logic [431:0] Color_R;
   logic [431:0] Color_G;
   logic [431:0] Color_B;
   logic         busy;
   logic         done;
   logic         err;

   typedef struct {
      bit           is_err;
      logic [431:0] r;
      logic [431:0] g;
      logic [431:0] b;
   } exp_t;

   exp_t         sb_q[$];
   int           n_chk  = 0;
   int           n_pass = 0;
   logic [431:0] m_r, m_g, m_b;

   facelet_sampler u_dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .PixX        (PixX),
      .PixY        (PixY),
      .PixR        (PixR),
      .PixG        (PixG),
      .PixB        (PixB),
      .capture_req (capture_req),
      .face_sel    (face_sel),
      .Color_R     (Color_R),
      .Color_G     (Color_G),
      .Color_B     (Color_B),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [431:0] act, input logic [431:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, req);
   endtask

   task automatic set_fl(input int i, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
      m_r[431-8*i -: 8] = r;
      m_g[431-8*i -: 8] = g;
      m_b[431-8*i -: 8] = b;
   endtask

   task automatic push_store();
      exp_t e;
      e.is_err = 1'b0;
      e.r = m_r;
      e.g = m_g;
      e.b = m_b;
      sb_q.push_back(e);
   endtask

   // Monitor: every done/err pulse must match the oldest expected event.
   always @(negedge Clk) begin : monitor
      exp_t e;
      if (!Reset && (done || err)) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: done=%0b err=%0b, scoreboard empty", done, err);
         end else begin
            e = sb_q.pop_front();
            check("event_is_err", 432'(err), 432'(e.is_err));
            if (!e.is_err) begin
               check("store_R", Color_R, e.r);
               check("store_G", Color_G, e.g);
               check("store_B", Color_B, e.b);
               check("busy_low_at_done", 432'(busy), 432'(0));
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
      pix_valid = 1'b1;
      PixX = 10'(x);
      PixY = 10'(y);
      PixR = r;
      PixG = g;
      PixB = b;
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic start_capture(input logic [2:0] f);
      capture_req = 1'b1;
      face_sel = f;
      tick();
      capture_req = 1'b0;
   endtask

   function automatic bit in_win_ref(input int x, input int y, output int k);
      k = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            if (x >= 196 + 80*c && x <= 203 + 80*c && y >= 116 + 80*r && y <= 123 + 80*r) begin
               k = 3*r + c;
               return 1'b1;
            end
      return 1'b0;
   endfunction

   // Sparse frame: a 12x12 patch around every window centre, including a
   // 2-pixel ring just outside each window carrying the value ob.
   task automatic send_frame(input logic [7:0] ir, input logic [7:0] ig, input logic [7:0] ib,
                             input logic [7:0] ob, input bit raster, input bit inject);
      int k;
      logic [7:0] r, g, b;
      for (int wr = 0; wr < 3; wr++)
         for (int wc = 0; wc < 3; wc++)
            for (int y = 114 + 80*wr; y <= 125 + 80*wr; y++)
               for (int x = 194 + 80*wc; x <= 205 + 80*wc; x++) begin
                  if (in_win_ref(x, y, k)) begin
                     if (raster) begin
                        r = (k == 4) ? 8'((y - 196)*8 + (x - 276)) : 8'h00;
                        g = 8'h00;
                        b = 8'h00;
                     end else begin
                        r = ir; g = ig; b = ib;
                     end
                  end else begin
                     r = raster ? 8'h00 : ob;
                     g = r;
                     b = r;
                  end
                  drive_pix(x, y, r, g, b);
                  if (inject && wr == 1 && wc == 1 && x == 200 && y == 200) begin
                     start_capture(3'd2);
                  end
               end
   endtask

   // Terminating frame_start (its pixel lies in window 0 and must be ignored),
   // then measure the done latency from the sampling edge.
   task automatic term_sof();
      int n;
      frame_start = 1'b1;
      pix_valid = 1'b1;
      PixX = 10'd197;
      PixY = 10'd120;
      PixR = 8'hFF;
      PixG = 8'hFF;
      PixB = 8'hFF;
      tick();
      frame_start = 1'b0;
      pix_valid = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check("done_latency", 432'(n), 432'(10));
      tick();
      check("done_one_cycle", 432'(done), 432'(0));
      check("busy_after_done", 432'(busy), 432'(0));
   endtask

   task automatic run_capture(input logic [2:0] f, input logic [7:0] ir, input logic [7:0] ig,
                              input logic [7:0] ib, input logic [7:0] ob, input bit raster,
                              input bit inject);
      start_capture(f);
      drive_pix(200, 120, 8'hFF, 8'hFF, 8'hFF);  // WAIT_SOF, not frame_start: ignored
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      send_frame(ir, ig, ib, ob, raster, inject);
      push_store();
      term_sof();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      exp_t e;
      Reset = 1'b1;
      frame_start = 1'b0;
      pix_valid = 1'b0;
      PixX = '0;
      PixY = '0;
      PixR = '0;
      PixG = '0;
      PixB = '0;
      capture_req = 1'b0;
      face_sel = '0;
      m_r = '0;
      m_g = '0;
      m_b = '0;

      // 1: reset state
      tick();
      tick();
      Reset = 1'b0;
      check("reset_R", Color_R, 432'(0));
      check("reset_G", Color_G, 432'(0));
      check("reset_B", Color_B, 432'(0));
      check("reset_busy", 432'(busy), 432'(0));
      check("reset_done", 432'(done), 432'(0));
      check("reset_err", 432'(err), 432'(0));

      // 2: uniform frame into face 0
      for (int i = 0; i < 9; i++) set_fl(i, 8'h40, 8'h80, 8'hC0);
      run_capture(3'd0, 8'h40, 8'h80, 8'hC0, 8'h40, 1'b0, 1'b0);

      // 3: raster ramp in window 4 of face 5 -> 2016 >> 6 = 0x1F
      set_fl(49, 8'h1F, 8'h00, 8'h00);
      run_capture(3'd5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

      // 4: window 0 boundaries on face 3 -> two 0xFF pixels, 0x1FE >> 6 = 0x07
      start_capture(3'd3);
      frame_start = 1'b1;
      pix_valid = 1'b1;
      PixX = 10'd196;
      PixY = 10'd120;
      PixR = 8'hFF;
      PixG = 8'hFF;
      PixB = 8'hFF;
      tick();
      frame_start = 1'b0;
      pix_valid = 1'b0;
      drive_pix(203, 120, 8'hFF, 8'hFF, 8'hFF);
      drive_pix(195, 120, 8'hFF, 8'hFF, 8'hFF);
      drive_pix(204, 120, 8'hFF, 8'hFF, 8'hFF);
      drive_pix(200, 124, 8'hFF, 8'hFF, 8'hFF);
      set_fl(27, 8'h07, 8'h07, 8'h07);
      push_store();
      term_sof();

      // 5: invalid face in IDLE, then a request injected during ACCUM
      e.is_err = 1'b1;
      e.r = '0;
      e.g = '0;
      e.b = '0;
      sb_q.push_back(e);
      start_capture(3'd6);
      check("err_busy_low", 432'(busy), 432'(0));
      tick();
      check("err_one_cycle", 432'(err), 432'(0));
      check("err_still_idle", 432'(busy), 432'(0));
      for (int i = 36; i < 45; i++) set_fl(i, 8'h11, 8'h22, 8'h33);
      run_capture(3'd4, 8'h11, 8'h22, 8'h33, 8'hEE, 1'b0, 1'b1);

      // 6: reset mid-ACCUM, then a clean capture of face 1
      start_capture(3'd1);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int x = 196; x < 204; x++) drive_pix(x, 118, 8'hFF, 8'hFF, 8'hFF);
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      check("midreset_R", Color_R, 432'(0));
      check("midreset_G", Color_G, 432'(0));
      check("midreset_B", Color_B, 432'(0));
      check("midreset_busy", 432'(busy), 432'(0));
      m_r = '0;
      m_g = '0;
      m_b = '0;
      for (int i = 9; i < 18; i++) set_fl(i, 8'h08, 8'h10, 8'h18);
      run_capture(3'd1, 8'h08, 8'h10, 8'h18, 8'hEE, 1'b0, 1'b0);

      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("scoreboard_drained", 432'(sb_q.size()), 432'(0));
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/facelet_sampler.md
Name: facelet_sampler

Overview:
- Capture sequencer that fills the 54-facelet RGB colour store read by the VGA colour mapper.
- On a capture request for one cube face (0-5), it waits for the next camera frame start and accumulates RGB over 9 square windows placed on a 3x3 grid for one full frame.
- It then commits the 9 window averages into that face's slots of the packed colour vectors, which drive the mapper's Color_R/G/B inputs directly.

Parameters:
- GRID_X0, 200, x centre of grid column 0 (pixels)
- GRID_Y0, 120, y centre of grid row 0 (pixels)
- GRID_PITCH, 80, centre-to-centre spacing, same in x and y
- WIN_LOG2, 3, log2 of the window side; side WIN = 8, 64 pixels per window; WIN < GRID_PITCH is required

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse marking the first pixel of a camera frame
- pix_valid  in  1  PixX/PixY/PixR/PixG/PixB are valid this cycle
- PixX  in  10  pixel column
- PixY  in  10  pixel row
- PixR  in  8  red sample
- PixG  in  8  green sample
- PixB  in  8  blue sample
- capture_req  in  1  one-cycle request to capture a face
- face_sel  in  3  face to capture; sampled with capture_req
- Color_R  out  432  packed red store; facelet i occupies bits [431-8i -: 8]
- Color_G  out  432  packed green store, same layout
- Color_B  out  432  packed blue store, same layout
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a commit completes
- err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-operation):
  - state = IDLE; all accumulators = 0; Color_R/G/B = all 0.
  - busy = 0, done = 0, err = 0.
- Windows: column c, row r (0..2) has centre cx = GRID_X0 + c*GRID_PITCH, cy = GRID_Y0 + r*GRID_PITCH.
  - A pixel is in window k = 3r + c iff cx - WIN/2 <= PixX <= cx + WIN/2 - 1 and the same test holds for PixY.
  - Each pixel belongs to at most one window.
- Accumulators: 9 windows x 3 channels, each (8 + 2*WIN_LOG2) = 14 bits unsigned. Sums cannot overflow for one frame.
- FSM:
  - IDLE:
    - capture_req with face_sel <= 5: latch face_sel, clear all accumulators, go to WAIT_SOF.
    - capture_req with face_sel >= 6: err = 1 for one cycle, stay in IDLE.
  - WAIT_SOF: on frame_start go to ACCUM. A pixel presented in that same cycle is accumulated, since it is the frame's first pixel.
  - ACCUM:
    - Each pix_valid pixel inside window k adds PixR/G/B to that window's sums.
    - The next frame_start goes to COMMIT. The pixel in that cycle is not accumulated.
  - COMMIT: 9 cycles, index k = 0..8, one per cycle.
    - Write sum >> (2*WIN_LOG2) into facelet i = 9*face + k of all three vectors.
    - All other facelets are unchanged.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Timing: COMMIT writes land on edges t+1..t+9, where t is the edge that sampled the terminating frame_start. done is high during the cycle after edge t+10.
- Requests outside IDLE:
  - capture_req is ignored in every state except IDLE: no err, no state change.
  - capture_req in the same cycle that DONE exits is also ignored.
- Pixels arriving in IDLE, WAIT_SOF (except the frame_start cycle), COMMIT or DONE are ignored.
- Outputs are registered. Color vectors change only on COMMIT edges or on reset.

Decomposition:
- Shared package (facelet_pkg):
  - NUM_FACES = 6, FACELETS_PER_FACE = 9, NUM_FACELETS = 54, CH_W = 8.
  - typedef sampler_state_t {IDLE, WAIT_SOF, ACCUM, COMMIT, DONE}.
  - A function returning the MSB index of facelet i: 431 - 8i.
- One sub-module, facelet_window_decode:
  - Combinational; inputs PixX, PixY.
  - Outputs in_win (1 bit) and win_idx (4 bits), computed from the grid parameters.

Test Plan:
1. Hold Reset for 2 cycles -> Color_R/G/B all 0; busy, done and err all 0.
2. capture_req with face_sel = 0, then a full 640x480 frame at R=0x40, G=0x80, B=0xC0, then frame_start -> Color_R[431:360] all 0x40, Color_G all 0x80, Color_B all 0xC0, the rest 0. done pulses once, 10 cycles after the terminating frame_start edge; busy then falls.
3. face_sel = 5; window 4 (centre 280,200) gets R values 0..63 in raster order, all other pixels 0 -> facelet 49 R = 0x1F (2016 >> 6). The other face-5 facelets are 0, and face-0 data from test 2 is preserved.
4. Boundary pixels, each value 0xFF, around window 0 -> pixels at x = 196 and x = 203 (y = 120) are counted, giving sum 0x1FE and average 0x07. Pixels at x = 195, x = 204 and y = 124 are not counted.
5. capture_req with face_sel = 6 in IDLE -> err pulses 1 cycle, busy stays 0. capture_req with face_sel = 2 during ACCUM -> ignored; capture proceeds with the original face only.
6. Reset asserted mid-ACCUM, then a new capture with face_sel = 1 -> state returns to IDLE and the store clears to 0. The new capture yields averages from the new frame only, with no residual sums.
